wash_seq_ctrl: RTL and testbench
================================

Name: wash_seq_ctrl

Overview:
- Parametrised successor to the team's fixed five-stage, fixed-timer washing machine controller FSM.
- Sequences up to NUM_STAGES programme stages. Each stage has its own duration and an enable bit, so stages can be skipped.
- Supports pause/resume without losing stage or remaining time, an abort input, and status outputs.
- Sits between the front-panel decode logic and the motor/valve drive decode, which consumes the stage index.

Parameters:
- NUM_STAGES, 5, number of programme stages (2..15).
- CNT_W, 8, width of each per-stage duration field and of the down-counter.
- STAGE_W, $clog2(NUM_STAGES+1), width of the stage index. The all-ones value is reserved as IDLE_CODE.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous reset, active-high.
- start  in  1  begins a programme from IDLE or DONE; resumes from PAUSED.
- pause  in  1  freezes a running programme.
- abort  in  1  cancels the programme and returns to IDLE.
- stage_en  in  NUM_STAGES  per-stage enable; bit i enables stage i.
- stage_dur  in  NUM_STAGES*CNT_W  per-stage duration in cycles; field i is bits [i*CNT_W +: CNT_W].
- stage  out  STAGE_W  current stage index; IDLE_CODE when not in a stage.
- remaining  out  CNT_W  cycles left in the current stage, including the current cycle; 0 when not in a stage.
- busy  out  1  high in RUN or PAUSED.
- paused  out  1  high in PAUSED.
- done  out  1  high in DONE; held until start or abort.

Behaviour:
- States: IDLE, RUN, PAUSED, DONE.
- Reset (synchronous, highest priority) sets:
  - state=IDLE, stage=IDLE_CODE, remaining=0;
  - busy=0, paused=0, done=0;
  - latched enable mask = 0.
- Priority below reset: abort > pause > start.
- abort, in any state: next edge goes to IDLE with all outputs at their reset values. A pending pause or start in the same cycle is ignored.
- Programme start (IDLE or DONE with start=1, pause=0):
  - stage_en is latched into an internal mask. The mask is fixed for the rest of the programme; later stage_en changes have no effect until the next start.
  - If the mask is nonzero: next edge enters RUN with stage = lowest enabled index and remaining = max(stage_dur[that stage], 1). done clears on that edge.
  - If the mask is zero: next edge enters DONE directly with done=1 and stage=IDLE_CODE.
- RUN, pause=0:
  - If remaining > 1: remaining decrements by 1 and stage holds.
  - If remaining == 1 and a higher enabled stage exists: stage = lowest enabled index > current, and remaining = max(stage_dur[new], 1). stage_dur is sampled only on stage entry.
  - If remaining == 1 and no higher enabled stage exists: DONE, stage=IDLE_CODE, remaining=0, done=1.
- Stage timing: a stage with duration D (D=0 counts as 1) presents its index on the stage output for exactly D consecutive RUN cycles. There are no gap cycles between stages.
- RUN with pause=1: next edge goes to PAUSED. stage and remaining hold their current values (no decrement that cycle). paused=1, busy stays 1.
- PAUSED:
  - Holds while pause=1 or start=0.
  - start=1 with pause=0: next edge returns to RUN. Counting resumes on the following cycle from the held remaining value.
- pause in IDLE or DONE: ignored (no state change; done holds).
- start while already in RUN: ignored.
- DONE: done=1 until start (new programme) or abort/reset.
- start and pause together in PAUSED: pause wins, so the block stays PAUSED.
- Duration of all-ones: counts 2^CNT_W-1 cycles; no overflow path.

Decomposition:
- Shared package wash_pkg holds:
  - the state enum typedef (IDLE, RUN, PAUSED, DONE);
  - the IDLE_CODE constant function of STAGE_W;
  - a helper for the duration-field slice.
- One sub-module: wash_next_stage. It is combinational and takes the mask, the current index and a from_idle flag. It returns the next enabled index and a valid bit (a priority finder over mask bits above the current index). The FSM and counter stay in wash_seq_ctrl.

Test Plan (NUM_STAGES=5, CNT_W=4 unless noted):
1. Full programme: stage_en=5'b11111, all durations=3, start pulse.
   - stage reads 0,0,0,1,1,1,…,4,4,4 over 15 cycles.
   - done=1 on the 16th edge with stage=7.
2. Skip and zero duration: stage_en=5'b10101, durations {2,9,0,9,1} for stages 0..4.
   - stage reads 0,0,2,4, then DONE on the next edge.
   - remaining reads 2,1,1,1.
3. Pause/resume: durations=4; assert pause when stage=1 and remaining=2; hold 5 cycles; then start.
   - stage=1, remaining=2 and paused=1 throughout the pause.
   - After resume, remaining reads 2,1, then stage 2.
   - Total RUN cycles = 20.
4. Abort and precedence: during stage 3, assert abort, pause and start in the same cycle.
   - Next edge: IDLE, stage=7, busy=0, done=0.
   - A later start begins at stage 0.
5. Edge cases:
   - stage_en=0 with start: DONE on the next edge.
   - start in DONE: restarts and clears done.
   - reset asserted mid-stage 2: all outputs return to reset values on that edge.
6. NUM_STAGES=12, CNT_W=2 (STAGE_W=4, IDLE_CODE=15), alternate enables: check index wrap-free sequencing 0,2,…,10 and duration saturation at 3.

Source files
------------

// File: rtl/wash_pkg.sv
// rtl/wash_pkg.sv - shared types and helpers for the wash sequencer
package wash_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } wash_state_e;

  // The all-ones stage index is reserved to mean "not in a stage".
  function automatic int unsigned idle_code(input int unsigned stage_w);
    return (32'd1 << stage_w) - 32'd1;
  endfunction

  function automatic int unsigned dur_lsb(input int unsigned idx, input int unsigned cnt_w);
    return idx * cnt_w;
  endfunction

endpackage

// File: rtl/wash_next_stage.sv
// rtl/wash_next_stage.sv - priority finder for the next enabled stage
module wash_next_stage
  import wash_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int STAGE_W    = $clog2(NUM_STAGES + 1)
) (
  input  logic [NUM_STAGES-1:0] mask,
  input  logic [STAGE_W-1:0]    cur,
  input  logic                  from_idle,
  output logic [STAGE_W-1:0]    nxt,
  output logic                  valid
);

  // Scan downwards so the lowest qualifying index is the last one written.
  always_comb begin
    nxt   = '0;
    valid = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (mask[i] && (from_idle || (STAGE_W'(i) > cur))) begin
        nxt   = STAGE_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wash_seq_ctrl.sv
// rtl/wash_seq_ctrl.sv - parametrised washing programme sequencer
module wash_seq_ctrl
  import wash_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int CNT_W      = 8,
  parameter int STAGE_W    = $clog2(NUM_STAGES + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        pause,
  input  logic                        abort,
  input  logic [NUM_STAGES-1:0]       stage_en,
  input  logic [NUM_STAGES*CNT_W-1:0] stage_dur,
  output logic [STAGE_W-1:0]          stage,
  output logic [CNT_W-1:0]            remaining,
  output logic                        busy,
  output logic                        paused,
  output logic                        done
);

  localparam logic [STAGE_W-1:0] IDLE_CODE = STAGE_W'(idle_code(STAGE_W));

  wash_state_e             state_q, state_d;
  logic [STAGE_W-1:0]      stage_q, stage_d;
  logic [CNT_W-1:0]        rem_q, rem_d;
  logic [NUM_STAGES-1:0]   mask_q, mask_d;

  logic                    at_rest;
  logic [NUM_STAGES-1:0]   find_mask;
  logic [STAGE_W-1:0]      nxt_idx;
  logic                    nxt_valid;
  logic [CNT_W-1:0]        nxt_raw;
  logic [CNT_W-1:0]        nxt_dur;

  // From IDLE/DONE the search runs over the live enables; otherwise over the latched mask.
  assign at_rest   = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign find_mask = at_rest ? stage_en : mask_q;

  wash_next_stage #(
    .NUM_STAGES(NUM_STAGES),
    .STAGE_W   (STAGE_W)
  ) u_next (
    .mask     (find_mask),
    .cur      (stage_q),
    .from_idle(at_rest),
    .nxt      (nxt_idx),
    .valid    (nxt_valid)
  );

  always_comb begin
    nxt_raw = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (nxt_idx == STAGE_W'(i)) nxt_raw = stage_dur[dur_lsb(i, CNT_W) +: CNT_W];
    end
  end

  assign nxt_dur = (nxt_raw == '0) ? CNT_W'(1) : nxt_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      stage_q <= IDLE_CODE;
      rem_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      rem_q   <= rem_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    rem_d   = rem_q;
    mask_d  = mask_q;
    if (abort) begin
      state_d = ST_IDLE;
      stage_d = IDLE_CODE;
      rem_d   = '0;
      mask_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start && !pause) begin
            mask_d = stage_en;
            if (nxt_valid) begin
              state_d = ST_RUN;
              stage_d = nxt_idx;
              rem_d   = nxt_dur;
            end else begin
              state_d = ST_DONE;
              stage_d = IDLE_CODE;
              rem_d   = '0;
            end
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (rem_q > CNT_W'(1)) begin
            rem_d = rem_q - CNT_W'(1);
          end else if (nxt_valid) begin
            stage_d = nxt_idx;
            rem_d   = nxt_dur;
          end else begin
            state_d = ST_DONE;
            stage_d = IDLE_CODE;
            rem_d   = '0;
          end
        end
        ST_PAUSED: begin
          if (start && !pause) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy   = (state_q == ST_RUN) || (state_q == ST_PAUSED);
    paused = (state_q == ST_PAUSED);
    done   = (state_q == ST_DONE);
  end

  assign stage     = stage_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_wash_seq_ctrl.sv
// tb/tb_wash_seq_ctrl.sv - directed vector bench for wash_seq_ctrl
module tb_wash_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, pause, abort;
  logic [4:0]  stage_en;
  logic [19:0] stage_dur;
  logic [2:0]  stage;
  logic [3:0]  remaining;
  logic        busy, paused, done;

  logic        reset_b, start_b, pause_b, abort_b;
  logic [11:0] en_b;
  logic [23:0] dur_b;
  logic [3:0]  stage_b;
  logic [1:0]  rem_b;
  logic        busy_b, paused_b, done_b;

  wash_seq_ctrl #(.NUM_STAGES(5), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .abort(abort),
    .stage_en(stage_en), .stage_dur(stage_dur), .stage(stage), .remaining(remaining),
    .busy(busy), .paused(paused), .done(done)
  );

  wash_seq_ctrl #(.NUM_STAGES(12), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .pause(pause_b), .abort(abort_b),
    .stage_en(en_b), .stage_dur(dur_b), .stage(stage_b), .remaining(rem_b),
    .busy(busy_b), .paused(paused_b), .done(done_b)
  );

  typedef struct {
    logic        rst, st, pa, ab;
    logic [4:0]  en;
    logic [19:0] dur;
    logic [2:0]  stg;
    logic [3:0]  rem;
    logic        bsy, psd, dn;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;
  int run_cnt;
  bit found;

  function automatic vec_t mk(input int rst, input int st, input int pa, input int ab,
                              input int en, input int dur, input int stg, input int rem,
                              input int bsy, input int psd, input int dn);
    vec_t v;
    v.rst = rst[0]; v.st = st[0]; v.pa = pa[0]; v.ab = ab[0];
    v.en  = en[4:0]; v.dur = dur[19:0];
    v.stg = stg[2:0]; v.rem = rem[3:0];
    v.bsy = bsy[0]; v.psd = psd[0]; v.dn = dn[0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam int D2 = 32'h19092; // stages 0..4 = 2,9,0,9,1
  localparam int D1 = 32'h11111;

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
    stage_en = '0; stage_dur = '0;
    reset_b = 1'b1; start_b = 1'b0; pause_b = 1'b0; abort_b = 1'b0;
    en_b = '0; dur_b = '0;

    //             rst st pa ab  en     dur  stg rem b p d
    vecs.push_back(mk(1, 0, 0, 0, 5'h00, 0,  7, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 5'h15, D2, 0, 2, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 5'h1f, D2, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 5'h1f, D2, 2, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 5'h1f, D2, 4, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 5'h1f, D2, 7, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 5'h1f, D2, 7, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 5'h01, D2, 0, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 5'h01, D2, 7, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 5'h00, D2, 7, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 5'h00, D2, 7, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 5'h1f, D1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 5'h1f, D1, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 5'h1f, D1, 2, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 5'h1f, D1, 3, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 5'h1f, D1, 7, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 5'h1f, D1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 5'h1f, D1, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 5'h1f, D1, 2, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 5'h1f, D1, 7, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 5'h1f, D1, 7, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 5'h1f, D1, 7, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      reset = vecs[i].rst; start = vecs[i].st; pause = vecs[i].pa; abort = vecs[i].ab;
      stage_en = vecs[i].en; stage_dur = vecs[i].dur;
      step();
      chk($sformatf("v%0d stage", i),     32'(stage),     32'(vecs[i].stg));
      chk($sformatf("v%0d remaining", i), 32'(remaining), 32'(vecs[i].rem));
      chk($sformatf("v%0d busy", i),      32'(busy),      32'(vecs[i].bsy));
      chk($sformatf("v%0d paused", i),    32'(paused),    32'(vecs[i].psd));
      chk($sformatf("v%0d done", i),      32'(done),      32'(vecs[i].dn));
    end
    reset = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;

    // Full five-stage programme, three cycles each.
    reset = 1'b1; step(); reset = 1'b0;
    stage_en = 5'h1f; stage_dur = 20'h33333; start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("t1 stage k%0d", k), 32'(stage),     32'(k / 3));
      chk($sformatf("t1 rem k%0d", k),   32'(remaining), 32'(3 - k % 3));
      step();
    end
    chk("t1 done", 32'(done), 32'd1);
    chk("t1 idle stage", 32'(stage), 32'd7);

    // Pause at stage 1 with two cycles left, hold, then resume.
    reset = 1'b1; step(); reset = 1'b0;
    stage_dur = 20'h44444; start = 1'b1; step(); start = 1'b0;
    run_cnt = 0; found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (stage == 3'd1 && remaining == 4'd2) found = 1'b1;
      else begin
        if (busy && !paused) run_cnt++;
        step();
      end
    end
    chk("t3 reach s1r2", 32'(found), 32'd1);
    pause = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      chk($sformatf("t3 hold paused %0d", n), 32'(paused),    32'd1);
      chk($sformatf("t3 hold stage %0d", n),  32'(stage),     32'd1);
      chk($sformatf("t3 hold rem %0d", n),    32'(remaining), 32'd2);
    end
    pause = 1'b0; start = 1'b1; step(); start = 1'b0;
    chk("t3 resume paused", 32'(paused), 32'd0);
    chk("t3 resume rem2", 32'(remaining), 32'd2);
    if (busy && !paused) run_cnt++;
    step();
    chk("t3 resume rem1", 32'(remaining), 32'd1);
    if (busy && !paused) run_cnt++;
    step();
    chk("t3 next stage", 32'(stage), 32'd2);
    for (int n = 0; n < 40 && !done; n++) begin
      if (busy && !paused) run_cnt++;
      step();
    end
    chk("t3 done", 32'(done), 32'd1);
    chk("t3 run cycles", 32'(run_cnt), 32'd20);

    // Twelve-stage instance, alternate enables, saturated two-bit durations.
    step(); reset_b = 1'b0;
    en_b = 12'b0101_0101_0101; dur_b = 24'hFFFFFF; start_b = 1'b1; step(); start_b = 1'b0;
    for (int k = 0; k < 18; k++) begin
      chk($sformatf("t6 stage k%0d", k), 32'(stage_b), 32'(2 * (k / 3)));
      chk($sformatf("t6 rem k%0d", k),   32'(rem_b),   32'(3 - k % 3));
      step();
    end
    chk("t6 done", 32'(done_b), 32'd1);
    chk("t6 idle stage", 32'(stage_b), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
